wfg_drive_spi_mc: RTL and testbench

- Second-generation SPI drive core for the waveform generator.
- Consumes AXI-Stream samples on each wfg_core_sync_i pulse and serialises them over SPI.
- Adds the following over the previous drive: configurable clock divider, all four CPOL/CPHA modes, 8/16/24/32-bit frames, MSB/LSB-first, NUM_CS chip selects, tlast-controlled CS hold between words, SDI capture and error flags.
- Sits between the wfg_core/stream fabric and pads. The Wishbone register file lives in a separate top and drives the cfg_* inputs.

---
 rtl/wfg_drive_spi_mc_pkg.sv | 46 ++++
 rtl/wfg_drive_spi_mc_clkgen.sv | 50 +++++
 rtl/wfg_drive_spi_mc.sv | 245 ++++++++++++++++++++++++
 tb/tb_wfg_drive_spi_mc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfg_drive_spi_mc_pkg.sv
// -----------------------------------------------------------------------------
// wfg_drive_spi_mc_pkg
// Shared types and helpers for the second-generation SPI drive core.
//   state_t        : frame-sequencer states
//   DFF_*          : frame-size encodings carried on cfg_dff_i
//   frame_bits()   : frame-size encoding -> number of bits (8..32)
//   bit_rev32()    : full 32-bit bit reversal, used for LSB-first ordering
// -----------------------------------------------------------------------------
package wfg_drive_spi_mc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        CS_HOLD
    } state_t;

    localparam logic [1:0] DFF_8  = 2'd0;
    localparam logic [1:0] DFF_16 = 2'd1;
    localparam logic [1:0] DFF_24 = 2'd2;
    localparam logic [1:0] DFF_32 = 2'd3;

    // Largest frame; the shift registers are sized for it.
    localparam int unsigned MAX_FRAME_BITS = 32;

    function automatic logic [5:0] frame_bits(input logic [1:0] dff);
        logic [5:0] bits;
        unique case (dff)
            DFF_8:   bits = 6'd8;
            DFF_16:  bits = 6'd16;
            DFF_24:  bits = 6'd24;
            default: bits = 6'd32;
        endcase
        return bits;
    endfunction

    function automatic logic [31:0] bit_rev32(input logic [31:0] value);
        logic [31:0] rev;
        for (int i = 0; i < 32; i++) begin
            rev[i] = value[31-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/wfg_drive_spi_mc_clkgen.sv
// -----------------------------------------------------------------------------
// wfg_drive_spi_mc_clkgen
// Half-period timer for the SPI drive. Counts 0..div while run is high and
// emits a one-cycle tick at the end of each half-period. parity toggles on
// every tick, so after a restart it equals the number of ticks seen, mod 2.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : frame-start strobe; clears counter and parity
//   run        : count enable (high while a frame is in progress)
//   div        : half-period length minus one, in clk cycles
//   tick       : end-of-half-period pulse
//   parity     : tick count since restart, mod 2
// -----------------------------------------------------------------------------
module wfg_drive_spi_mc_clkgen
    import wfg_drive_spi_mc_pkg::*;
#(
    parameter int CLKDIV_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    restart,
    input  logic                    run,
    input  logic [CLKDIV_WIDTH-1:0] div,
    output logic                    tick,
    output logic                    parity
);

    logic [CLKDIV_WIDTH-1:0] cnt_q;

    assign tick = run && !restart && (cnt_q == div);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            parity <= 1'b0;
        end else if (restart) begin
            cnt_q  <= '0;
            parity <= 1'b0;
        end else if (run) begin
            if (cnt_q == div) begin
                cnt_q  <= '0;
                parity <= ~parity;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wfg_drive_spi_mc.sv
// -----------------------------------------------------------------------------
// wfg_drive_spi_mc
// SPI drive core: on each wfg_core_sync_i pulse takes one AXI-Stream sample
// and shifts it out over SPI, capturing SDI in parallel.
//   wb_clk_i, wb_rst_ni       : clock, asynchronous active-low reset
//   wfg_core_sync_i           : frame-start pulse
//   wfg_core_subcycle_i       : unused
//   cfg_*                     : mode, bit order, frame size, CS index, divider
//   wfg_axis_t*               : stream input (tready is combinational)
//   wfg_drive_spi_sclk_o/cs_no/sdo_o/sdi_i : SPI pins
//   rx_data_o, rx_valid_o     : received frame, right-aligned, with strobe
//   busy_o                    : frame in progress
//   err_underrun_o/overrun_o  : sticky sync-without-data / sync-while-busy
// -----------------------------------------------------------------------------
module wfg_drive_spi_mc
    import wfg_drive_spi_mc_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int NUM_CS          = 4,
    parameter int CLKDIV_WIDTH    = 8
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       wfg_core_sync_i,
    input  logic                       wfg_core_subcycle_i,
    input  logic                       cfg_en_i,
    input  logic                       cfg_cpol_i,
    input  logic                       cfg_cpha_i,
    input  logic                       cfg_lsbfirst_i,
    input  logic [1:0]                 cfg_dff_i,
    input  logic [2:0]                 cfg_cs_sel_i,
    input  logic [CLKDIV_WIDTH-1:0]    cfg_clkdiv_i,
    output logic                       wfg_axis_tready_o,
    input  logic                       wfg_axis_tvalid_i,
    input  logic                       wfg_axis_tlast_i,
    input  logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_i,
    output logic                       wfg_drive_spi_sclk_o,
    output logic [NUM_CS-1:0]          wfg_drive_spi_cs_no,
    output logic                       wfg_drive_spi_sdo_o,
    input  logic                       wfg_drive_spi_sdi_i,
    output logic [31:0]                rx_data_o,
    output logic                       rx_valid_o,
    output logic                       busy_o,
    output logic                       err_underrun_o,
    output logic                       err_overrun_o
);

    state_t state_q, state_d;

    // Per-frame snapshot of configuration and stream sideband.
    logic                    cpol_q;
    logic                    cpha_q;
    logic                    lsb_q;
    logic [1:0]              dff_q;
    logic [2:0]              cs_idx_q;
    logic [CLKDIV_WIDTH-1:0] div_q;
    logic                    tlast_q;

    logic [MAX_FRAME_BITS-1:0] tx_sr_q;   // next bit to send is always [31]
    logic [MAX_FRAME_BITS-1:0] rx_sr_q;   // newest bit enters at [0]
    logic                      sdo_q;
    logic                      phase_q;   // SCLK relative to its idle level
    logic                      cs_active_q;
    logic [6:0]                edge_cnt_q;

    logic        idle_like;
    logic        xfer;
    logic        tick;
    logic        parity;
    logic [5:0]  n_bits;
    logic [6:0]  last_edge;
    logic        sample_edge;
    logic [31:0] tx_frame;
    logic [31:0] rx_aligned;

    // Interface-compatibility inputs and stream bits above the widest frame.
    logic unused_inputs;
    assign unused_inputs = ^{wfg_core_subcycle_i, wfg_axis_tdata_i};

    assign idle_like         = (state_q == IDLE) || (state_q == CS_HOLD);
    assign busy_o            = !idle_like;
    assign wfg_axis_tready_o = idle_like && cfg_en_i && wfg_core_sync_i;
    assign xfer              = wfg_axis_tready_o && wfg_axis_tvalid_i;

    assign n_bits    = frame_bits(dff_q);
    assign last_edge = {n_bits, 1'b0} - 7'd1;

    // parity equals the 1-based SHIFT edge index mod 2 at that edge's tick,
    // because the SETUP half-period contributes exactly one earlier tick.
    assign sample_edge = cpha_q ? !parity : parity;

    // Transmit word pre-aligned so the first bit on the wire sits at [31].
    assign tx_frame = cfg_lsbfirst_i
                    ? bit_rev32(wfg_axis_tdata_i[31:0])
                    : wfg_axis_tdata_i[31:0] << (6'd32 - frame_bits(cfg_dff_i));

    // rx_sr_q holds the first received bit at [N-1]; LSB-first puts it at [0].
    assign rx_aligned = lsb_q ? (bit_rev32(rx_sr_q) >> (6'd32 - n_bits)) : rx_sr_q;

    // Outside a frame SCLK follows the live idle level so reset and idle
    // both present cfg_cpol_i directly.
    assign wfg_drive_spi_sclk_o = busy_o ? (cpol_q ^ phase_q) : cfg_cpol_i;
    assign wfg_drive_spi_sdo_o  = sdo_q;

    always_comb begin
        wfg_drive_spi_cs_no = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_active_q && (cs_idx_q == 3'(i))) begin
                wfg_drive_spi_cs_no[i] = 1'b0;
            end
        end
    end

    wfg_drive_spi_mc_clkgen #(
        .CLKDIV_WIDTH(CLKDIV_WIDTH)
    ) u_clkgen (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .restart(xfer),
        .run    (busy_o),
        .div    (div_q),
        .tick   (tick),
        .parity (parity)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so every path assigns it;
    // a missing assignment in a combinational block would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) state_d = SETUP;
            end
            CS_HOLD: begin
                if (xfer)           state_d = SETUP;
                else if (!cfg_en_i) state_d = IDLE;
            end
            SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (tick && (edge_cnt_q == last_edge)) state_d = HOLD;
            end
            HOLD: begin
                if (tick) state_d = tlast_q ? IDLE : CS_HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            dff_q       <= DFF_8;
            cs_idx_q    <= '0;
            div_q       <= '0;
            tlast_q     <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            sdo_q       <= 1'b0;
            phase_q     <= 1'b0;
            cs_active_q <= 1'b0;
            edge_cnt_q  <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (xfer) begin
                cpol_q      <= cfg_cpol_i;
                cpha_q      <= cfg_cpha_i;
                lsb_q       <= cfg_lsbfirst_i;
                dff_q       <= cfg_dff_i;
                cs_idx_q    <= cfg_cs_sel_i;
                div_q       <= cfg_clkdiv_i;
                tlast_q     <= wfg_axis_tlast_i;
                rx_sr_q     <= '0;
                phase_q     <= 1'b0;
                edge_cnt_q  <= '0;
                cs_active_q <= 1'b1;
                if (!cfg_cpha_i) begin
                    // CPHA=0: first bit must be valid before the leading edge.
                    sdo_q   <= tx_frame[31];
                    tx_sr_q <= tx_frame << 1;
                end else begin
                    sdo_q   <= 1'b0;
                    tx_sr_q <= tx_frame;
                end
            end else begin
                unique case (state_q)
                    SHIFT: begin
                        if (tick) begin
                            phase_q    <= ~phase_q;
                            edge_cnt_q <= edge_cnt_q + 7'd1;
                            if (sample_edge) begin
                                rx_sr_q <= {rx_sr_q[30:0], wfg_drive_spi_sdi_i};
                            end else if (edge_cnt_q != last_edge) begin
                                sdo_q   <= tx_sr_q[31];
                                tx_sr_q <= tx_sr_q << 1;
                            end
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            rx_valid_o <= 1'b1;
                            rx_data_o  <= rx_aligned;
                            sdo_q      <= 1'b0;
                            if (tlast_q) cs_active_q <= 1'b0;
                        end
                    end
                    CS_HOLD: begin
                        if (!cfg_en_i) cs_active_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------ sticky errors
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            err_underrun_o <= 1'b0;
            err_overrun_o  <= 1'b0;
        end else if (!cfg_en_i) begin
            err_underrun_o <= 1'b0;
            err_overrun_o  <= 1'b0;
        end else if (wfg_core_sync_i) begin
            if (idle_like && !wfg_axis_tvalid_i) err_underrun_o <= 1'b1;
            if (!idle_like)                      err_overrun_o  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wfg_drive_spi_mc.sv
// -----------------------------------------------------------------------------
// tb_wfg_drive_spi_mc
// Directed bench for wfg_drive_spi_mc with SDI looped back to SDO. Each
// scenario task drives stimulus and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_wfg_drive_spi_mc;

    localparam int NUM_CS = 4;

    logic        clk;
    logic        rst_n;
    logic        sync;
    logic        subcycle;
    logic        en;
    logic        cpol;
    logic        cpha;
    logic        lsb;
    logic [1:0]  dff;
    logic [2:0]  cs_sel;
    logic [7:0]  clkdiv;
    logic        tready;
    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;
    logic        sclk;
    logic [NUM_CS-1:0] cs_no;
    logic        sdo;
    logic        sdi;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        err_under;
    logic        err_over;

    int n_tests = 0;
    int n_fail  = 0;

    // Window statistics filled in by monitor().
    int          mon_cs_low;
    int          mon_other_low;
    int          mon_rise;
    int          mon_toggles;
    int          mon_rxv;
    int          mon_first_edge;
    int          mon_second_edge;
    logic [31:0] mon_seq;
    logic [31:0] mon_rx;
    logic        mon_tready_seen;

    assign sdi = sdo;

    wfg_drive_spi_mc #(
        .AXIS_DATA_WIDTH(32),
        .NUM_CS         (NUM_CS),
        .CLKDIV_WIDTH   (8)
    ) dut (
        .wb_clk_i            (clk),
        .wb_rst_ni           (rst_n),
        .wfg_core_sync_i     (sync),
        .wfg_core_subcycle_i (subcycle),
        .cfg_en_i            (en),
        .cfg_cpol_i          (cpol),
        .cfg_cpha_i          (cpha),
        .cfg_lsbfirst_i      (lsb),
        .cfg_dff_i           (dff),
        .cfg_cs_sel_i        (cs_sel),
        .cfg_clkdiv_i        (clkdiv),
        .wfg_axis_tready_o   (tready),
        .wfg_axis_tvalid_i   (tvalid),
        .wfg_axis_tlast_i    (tlast),
        .wfg_axis_tdata_i    (tdata),
        .wfg_drive_spi_sclk_o(sclk),
        .wfg_drive_spi_cs_no (cs_no),
        .wfg_drive_spi_sdo_o (sdo),
        .wfg_drive_spi_sdi_i (sdi),
        .rx_data_o           (rx_data),
        .rx_valid_o          (rx_valid),
        .busy_o              (busy),
        .err_underrun_o      (err_under),
        .err_overrun_o       (err_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_cfg(input logic p, input logic h, input logic l,
                           input logic [1:0] d, input logic [2:0] c,
                           input logic [7:0] k);
        cpol = p; cpha = h; lsb = l; dff = d; cs_sel = c; clkdiv = k;
        #1;
    endtask

    // Present one word with a sync pulse; rdy is tready seen before the edge.
    task automatic send_word(input logic [31:0] d, input logic last, output logic rdy);
        tdata = d; tlast = last; tvalid = 1'b1; sync = 1'b1;
        #1 rdy = tready;
        @(posedge clk); #1;
        sync = 1'b0; tvalid = 1'b0;
    endtask

    // Sample outputs once per cycle (1 time unit after the rising edge).
    // ovr_at >= 0 injects a sync+tvalid pulse at that sample index.
    task automatic monitor(input int cycles, input int cs_idx, input int ovr_at);
        logic prev_sclk;
        mon_cs_low = 0; mon_other_low = 0; mon_rise = 0; mon_toggles = 0;
        mon_rxv = 0; mon_first_edge = -1; mon_second_edge = -1;
        mon_seq = '0; mon_rx = '0; mon_tready_seen = 1'b0;
        prev_sclk = sclk;
        for (int i = 0; i < cycles; i++) begin
            if (cs_no[cs_idx] === 1'b0) mon_cs_low++;
            for (int j = 0; j < NUM_CS; j++) begin
                if (j != cs_idx && cs_no[j] === 1'b0) mon_other_low++;
            end
            if (sclk !== prev_sclk) begin
                mon_toggles++;
                if (mon_first_edge < 0)       mon_first_edge = i;
                else if (mon_second_edge < 0) mon_second_edge = i;
                if (sclk === 1'b1) begin
                    mon_rise++;
                    mon_seq = {mon_seq[30:0], sdo};
                end
            end
            prev_sclk = sclk;
            if (rx_valid === 1'b1) begin
                mon_rxv++;
                mon_rx = rx_data;
            end
            if (i == ovr_at) begin
                tdata = 32'hFF; tlast = 1'b1; tvalid = 1'b1; sync = 1'b1;
                #1 mon_tready_seen = tready;
            end
            @(posedge clk); #1;
            sync = 1'b0; tvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sync = 1'b0; subcycle = 1'b0; en = 1'b1;
        tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        set_cfg(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        #3;
        n_tests++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk_cpol1: got %b expected 1", sclk); end
        cpol = 1'b0; #1;
        n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk_cpol0: got %b expected 0", sclk); end
        n_tests++; if (cs_no !== 4'hF) begin n_fail++; $display("FAIL reset_cs: got %h expected F", cs_no); end
        n_tests++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b expected 0", sdo); end
        n_tests++; if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b expected 0", tready); end
        n_tests++; if (rx_data !== 32'h0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx: got %h/%b expected 0/0", rx_data, rx_valid); end
        n_tests++; if ({err_under, err_over, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {err_under, err_over, busy}); end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mode0_msb();
        logic rdy;
        set_cfg(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        send_word(32'h0000_00A5, 1'b1, rdy);
        n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL m0_tready: got %b expected 1", rdy); end
        monitor(24, 0, -1);
        n_tests++; if (mon_cs_low != 18) begin n_fail++; $display("FAIL m0_cs_cycles: got %0d expected 18", mon_cs_low); end
        n_tests++; if (mon_rise != 8) begin n_fail++; $display("FAIL m0_rising: got %0d expected 8", mon_rise); end
        n_tests++; if (mon_seq[7:0] !== 8'hA5) begin n_fail++; $display("FAIL m0_sdo_seq: got %h expected a5", mon_seq[7:0]); end
        n_tests++; if (mon_rxv != 1 || mon_rx !== 32'h0000_00A5) begin n_fail++; $display("FAIL m0_rx: got %0d/%h expected 1/000000a5", mon_rxv, mon_rx); end
        n_tests++; if (cs_no !== 4'hF || sclk !== 1'b0) begin n_fail++; $display("FAIL m0_idle: got cs %h sclk %b expected F/0", cs_no, sclk); end
    endtask

    task automatic test_mode3_lsb();
        logic rdy;
        set_cfg(1'b1, 1'b1, 1'b1, 2'd1, 3'd2, 8'd3);
        n_tests++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_high: got %b expected 1", sclk); end
        send_word(32'h0000_1234, 1'b1, rdy);
        // Mid-frame changes must not affect the running frame.
        cs_sel = 3'd0; clkdiv = 8'd0; dff = 2'd0; lsb = 1'b0;
        monitor(144, 2, -1);
        n_tests++; if (mon_cs_low != 136) begin n_fail++; $display("FAIL m3_cs_cycles: got %0d expected 136", mon_cs_low); end
        n_tests++; if (mon_other_low != 0) begin n_fail++; $display("FAIL m3_other_cs: got %0d expected 0", mon_other_low); end
        n_tests++; if (mon_second_edge - mon_first_edge != 4) begin n_fail++; $display("FAIL m3_half_period: got %0d expected 4", mon_second_edge - mon_first_edge); end
        n_tests++; if (mon_toggles != 32) begin n_fail++; $display("FAIL m3_toggles: got %0d expected 32", mon_toggles); end
        n_tests++; if (mon_seq[15:0] !== 16'h2C48) begin n_fail++; $display("FAIL m3_sdo_seq: got %h expected 2c48", mon_seq[15:0]); end
        n_tests++; if (mon_rxv != 1 || mon_rx !== 32'h0000_1234) begin n_fail++; $display("FAIL m3_rx: got %0d/%h expected 1/00001234", mon_rxv, mon_rx); end
        n_tests++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_end_idle: got %b expected 1", sclk); end
    endtask

    task automatic test_back_to_back();
        logic rdy;
        set_cfg(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        send_word(32'h11, 1'b0, rdy);
        monitor(39, 0, -1);
        n_tests++; if (mon_cs_low != 39) begin n_fail++; $display("FAIL b2b_cs_held: got %0d expected 39", mon_cs_low); end
        n_tests++; if (mon_rxv != 1 || mon_rx !== 32'h11) begin n_fail++; $display("FAIL b2b_rx1: got %0d/%h expected 1/11", mon_rxv, mon_rx); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_gap: got %b expected 0", busy); end
        send_word(32'h22, 1'b1, rdy);
        n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_tready2: got %b expected 1", rdy); end
        monitor(25, 0, -1);
        n_tests++; if (mon_cs_low != 18) begin n_fail++; $display("FAIL b2b_cs2: got %0d expected 18", mon_cs_low); end
        n_tests++; if (mon_rxv != 1 || mon_rx !== 32'h22) begin n_fail++; $display("FAIL b2b_rx2: got %0d/%h expected 1/22", mon_rxv, mon_rx); end
        n_tests++; if (cs_no !== 4'hF) begin n_fail++; $display("FAIL b2b_release: got %h expected F", cs_no); end
    endtask

    task automatic test_errors();
        logic rdy;
        set_cfg(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 8'd1);
        sync = 1'b1; tvalid = 1'b0;
        @(posedge clk); #1;
        sync = 1'b0;
        n_tests++; if (err_under !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b expected 1", err_under); end
        n_tests++; if (cs_no !== 4'hF || busy !== 1'b0) begin n_fail++; $display("FAIL underrun_no_cs: got %h/%b expected F/0", cs_no, busy); end
        n_tests++; if (err_over !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", err_over); end
        send_word(32'h3C, 1'b1, rdy);
        monitor(42, 0, 10);
        n_tests++; if (mon_tready_seen !== 1'b0) begin n_fail++; $display("FAIL overrun_tready: got %b expected 0", mon_tready_seen); end
        n_tests++; if (err_over !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", err_over); end
        n_tests++; if (mon_cs_low != 36) begin n_fail++; $display("FAIL overrun_cs: got %0d expected 36", mon_cs_low); end
        n_tests++; if (mon_seq[7:0] !== 8'h3C || mon_rxv != 1 || mon_rx !== 32'h3C) begin n_fail++; $display("FAIL overrun_frame: got %h/%0d/%h expected 3c/1/3c", mon_seq[7:0], mon_rxv, mon_rx); end
        n_tests++; if (err_under !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b expected 1", err_under); end
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        n_tests++; if ({err_under, err_over} !== 2'b00) begin n_fail++; $display("FAIL err_clear_en: got %b expected 00", {err_under, err_over}); end
    endtask

    task automatic test_cfg_en();
        logic rdy;
        set_cfg(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        en = 1'b0;
        tdata = 32'h77; tlast = 1'b1; tvalid = 1'b1; sync = 1'b1;
        #1;
        n_tests++; if (tready !== 1'b0) begin n_fail++; $display("FAIL en0_tready: got %b expected 0", tready); end
        @(posedge clk); #1;
        sync = 1'b0; tvalid = 1'b0;
        monitor(30, 0, -1);
        n_tests++; if (mon_cs_low != 0 || mon_toggles != 0 || mon_rxv != 0) begin n_fail++; $display("FAIL en0_activity: got %0d/%0d/%0d expected 0/0/0", mon_cs_low, mon_toggles, mon_rxv); end
        en = 1'b1;
        send_word(32'h5A, 1'b0, rdy);
        monitor(22, 0, -1);
        n_tests++; if (cs_no[0] !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cshold_held: got %b/%b expected 0/0", cs_no[0], busy); end
        en = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (cs_no !== 4'hF) begin n_fail++; $display("FAIL cshold_release: got %h expected F", cs_no); end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        logic rdy;
        logic prev;
        logic reached;
        int   toggles;
        set_cfg(1'b0, 1'b0, 1'b0, 2'd3, 3'd1, 8'd0);
        send_word(32'hDEAD_BEEF, 1'b1, rdy);
        toggles = 0; prev = sclk; reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (sclk !== prev) toggles++;
            prev = sclk;
            if (toggles == 10) reached = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_tests++; if (reached !== 1'b1) begin n_fail++; $display("FAIL rst_edge10_reached: got %b expected 1", reached); end
        n_tests++; if (cs_no !== 4'hD || sdo !== 1'b1) begin n_fail++; $display("FAIL rst_pre_state: got %h/%b expected d/1", cs_no, sdo); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (cs_no !== 4'hF || sdo !== 1'b0) begin n_fail++; $display("FAIL rst_abort_pins: got %h/%b expected F/0", cs_no, sdo); end
        n_tests++; if (sclk !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_abort_idle: got %b/%b expected 0/0", sclk, busy); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        monitor(80, 1, -1);
        n_tests++; if (mon_rxv != 0 || mon_cs_low != 0 || mon_toggles != 0) begin n_fail++; $display("FAIL rst_no_resume: got %0d/%0d/%0d expected 0/0/0", mon_rxv, mon_cs_low, mon_toggles); end
        n_tests++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL rst_rx_data: got %h expected 0", rx_data); end
    endtask

    initial begin
        test_reset();
        test_mode0_msb();
        test_mode3_lsb();
        test_back_to_back();
        test_errors();
        test_cfg_en();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
